// File: rtl/lbist_ctrl.sv
// Logic BIST controller: sweeps every test pattern against each injected fault and counts detections.
// Define LBIST_EARLY_EXIT_EN to leave a fault's pattern sweep on its first detected mismatch.
module lbist_ctrl #(
  parameter int unsigned IN_BITS    = 4,
  parameter int unsigned OUT_BITS   = 4,
  parameter int unsigned NUM_FAULTS = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [OUT_BITS-1:0]               CUT_OP,
  input  logic [OUT_BITS-1:0]               FF_OP,
  output logic [IN_BITS-1:0]                TEST_IP,
  output logic                              inc,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_FAULTS)-1:0]     cur_fault,
  output logic [$clog2(NUM_FAULTS+1)-1:0]   det_cnt
);

  localparam int unsigned FW = $clog2(NUM_FAULTS);
  localparam int unsigned CW = $clog2(NUM_FAULTS + 1);
  localparam logic [IN_BITS-1:0] TipMax = '1;
  localparam logic [FW-1:0] LastFault = FW'(NUM_FAULTS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StNext,
    StSettle,
    StDone
  } state_e;

  state_e             r_state, w_state_d;
  logic [IN_BITS-1:0] r_test_ip, w_test_ip_d;
  logic [FW-1:0]      r_cur_fault, w_cur_fault_d;
  logic [CW-1:0]      r_det_cnt, w_det_cnt_d;
  logic               r_det, w_det_d;
  logic               w_inc;
  logic               w_mis;

  assign w_mis = (CUT_OP != FF_OP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_test_ip   <= '0;
      r_cur_fault <= '0;
      r_det_cnt   <= '0;
      r_det       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_test_ip   <= w_test_ip_d;
      r_cur_fault <= w_cur_fault_d;
      r_det_cnt   <= w_det_cnt_d;
      r_det       <= w_det_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_test_ip_d   = r_test_ip;
    w_cur_fault_d = r_cur_fault;
    w_det_cnt_d   = r_det_cnt;
    w_det_d       = r_det;
    w_inc         = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_d     = StApply;
          w_test_ip_d   = '0;
          w_cur_fault_d = '0;
          w_det_cnt_d   = '0;
          w_det_d       = 1'b0;
        end
      end
      StApply: begin
        // abort wins: the mismatch of this cycle must not reach det_cnt
        if (abort) begin
          w_state_d = StIdle;
        end else begin
          if (w_mis) w_det_d = 1'b1;
`ifdef LBIST_EARLY_EXIT_EN
          if (w_mis || (r_test_ip == TipMax)) w_state_d = StNext;
          else                                w_test_ip_d = r_test_ip + 1'b1;
`else
          if (r_test_ip == TipMax) w_state_d = StNext;
          else                     w_test_ip_d = r_test_ip + 1'b1;
`endif
        end
      end
      StNext: begin
        if (abort) begin
          w_state_d = StIdle;
        end else begin
          if (r_det) w_det_cnt_d = r_det_cnt + CW'(1);
          if (r_cur_fault != LastFault) begin
            w_inc     = 1'b1;
            w_state_d = StSettle;
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StSettle: begin
        if (abort) begin
          w_state_d = StIdle;
        end else begin
          w_cur_fault_d = r_cur_fault + 1'b1;
          w_test_ip_d   = '0;
          w_det_d       = 1'b0;
          w_state_d     = StApply;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign TEST_IP   = r_test_ip;
  assign inc       = w_inc;
  assign busy      = (r_state == StApply) || (r_state == StNext) || (r_state == StSettle);
  assign done      = (r_state == StDone);
  assign cur_fault = r_cur_fault;
  assign det_cnt   = r_det_cnt;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: emulates the faulty CUT from a per-fault mismatch table and predicts
// each run's latency, inc count and detections from the table alone.
module tb_lbist_ctrl;

  localparam int IB = 4;
  localparam int OB = 4;
  localparam int NF = 4;
  localparam int NPAT = 1 << IB;
  localparam int BUDGET = 2000;
`ifdef LBIST_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [OB-1:0] cut_op, ff_op;
  logic [IB-1:0] test_ip;
  logic          inc, busy, done;
  logic [1:0]    cur_fault;
  logic [2:0]    det_cnt;

  logic [NPAT-1:0] mis_tab [NF];
  logic [OB-1:0]   ff_val, mask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lbist_ctrl #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_FAULTS(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .CUT_OP    (cut_op),
    .FF_OP     (ff_op),
    .TEST_IP   (test_ip),
    .inc       (inc),
    .busy      (busy),
    .done      (done),
    .cur_fault (cur_fault),
    .det_cnt   (det_cnt)
  );

  // Faulty CUT: differs from the fault-free one wherever the table marks (fault, pattern)
  always_comb begin
    ff_op  = ff_val;
    cut_op = ff_val;
    if (mis_tab[cur_fault][test_ip] === 1'b1) cut_op = ff_val ^ mask;
  end

  // Expected outcome of one full run: patterns used per fault, one NEXT per fault, a SETTLE between
  function automatic void model_run(output int lat, output int det, output int last_tip);
    lat = 0;
    det = 0;
    last_tip = 0;
    for (int f = 0; f < NF; f++) begin
      int n;
      n = NPAT;
      if (EARLY) begin
        for (int p = 0; p < NPAT; p++) begin
          if (mis_tab[f][p]) begin
            n = p + 1;
            break;
          end
        end
      end
      if (mis_tab[f] != '0) det++;
      lat += n + 1 + ((f < NF - 1) ? 1 : 0);
      last_tip = n - 1;
    end
  endfunction

  task automatic fill_table(input int kind);
    for (int f = 0; f < NF; f++) begin
      case (kind)
        0: mis_tab[f] = '0;
        1: mis_tab[f] = '1;
        default: begin
          case ($urandom_range(0, 2))
            0:       mis_tab[f] = '0;
            1:       mis_tab[f] = NPAT'(1) << $urandom_range(0, NPAT - 1);
            default: mis_tab[f] = NPAT'($urandom) & NPAT'($urandom) & NPAT'($urandom);
          endcase
        end
      endcase
    end
    ff_val = OB'($urandom);
    mask   = OB'($urandom_range(1, (1 << OB) - 1));
  endtask

  task automatic run_measure(input bit hold, output int lat, output int incs, output bit tmo);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat = 0;
    incs = 0;
    tmo = 1'b0;
    while (done !== 1'b1) begin
      if (lat >= BUDGET) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      if (inc === 1'b1) incs++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fill_table(0);
    #1;
    n_checks++;
    if ({test_ip, inc, busy, done, cur_fault, det_cnt} !== '0)
      $display("FAIL reset outputs got tip=%0h inc=%b busy=%b done=%b flt=%0d det=%0d exp all 0",
               test_ip, inc, busy, done, cur_fault, det_cnt);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_release got busy=%b done=%b exp 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic check_run(input string name, input bit hold);
    int lat, incs, e_lat, e_det, e_tip;
    bit tmo;
    model_run(e_lat, e_det, e_tip);
    run_measure(hold, lat, incs, tmo);
    n_checks++;
    if (tmo) $display("FAIL %s timeout got no done exp done within %0d", name, BUDGET);
    else n_pass++;
    n_checks++;
    if (lat !== e_lat) $display("FAIL %s latency got %0d exp %0d", name, lat, e_lat);
    else n_pass++;
    n_checks++;
    if (incs !== NF - 1) $display("FAIL %s inc_pulses got %0d exp %0d", name, incs, NF - 1);
    else n_pass++;
    n_checks++;
    if (det_cnt !== 3'(e_det)) $display("FAIL %s det_cnt got %0d exp %0d", name, det_cnt, e_det);
    else n_pass++;
    n_checks++;
    if (cur_fault !== 2'(NF - 1) || test_ip !== 4'(e_tip) || busy !== 1'b0)
      $display("FAIL %s final got flt=%0d tip=%0d busy=%b exp flt=%0d tip=%0d busy=0",
               name, cur_fault, test_ip, busy, NF - 1, e_tip);
    else n_pass++;
  endtask

  task automatic test_no_mismatch();
    fill_table(0);
    check_run("no_mismatch", 1'b0);
  endtask

  task automatic test_single_mismatch();
    fill_table(0);
    mis_tab[1][10] = 1'b1;
    check_run("single_mismatch", 1'b0);
  endtask

  task automatic test_all_mismatch();
    fill_table(1);
    check_run("all_mismatch", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int e_lat, e_det, e_tip;
      fill_table(2);
      model_run(e_lat, e_det, e_tip);
      check_run("random", 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b1 || det_cnt !== 3'(e_det) || cur_fault !== 2'(NF - 1) ||
          test_ip !== 4'(e_tip))
        $display("FAIL done_hold got done=%b det=%0d flt=%0d tip=%0d exp 1 %0d %0d %0d",
                 done, det_cnt, cur_fault, test_ip, e_det, NF - 1, e_tip);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int cnt, e_det;
    bit found;
    fill_table(2);
    mis_tab[2] = 16'h0020;
    e_det = ((mis_tab[0] != '0) ? 1 : 0) + ((mis_tab[1] != '0) ? 1 : 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    found = 1'b0;
    while (!found && cnt < BUDGET) begin
      @(negedge clk);
      cnt++;
      if (busy === 1'b1 && cur_fault === 2'd2 && test_ip === 4'd5) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL abort_reach got no fault2/tip5 exp reached");
    else n_pass++;
    abort = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || inc !== 1'b0 || done !== 1'b0 || cur_fault !== 2'd2 ||
        det_cnt !== 3'(e_det))
      $display("FAIL abort got busy=%b inc=%b done=%b flt=%0d det=%0d exp 0 0 0 2 %0d",
               busy, inc, done, cur_fault, det_cnt, e_det);
    else n_pass++;
    @(negedge clk);
    abort = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || cur_fault !== 2'd2 || det_cnt !== 3'(e_det))
      $display("FAIL abort_idle got busy=%b flt=%0d det=%0d exp 0 2 %0d",
               busy, cur_fault, det_cnt, e_det);
    else n_pass++;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || cur_fault !== 2'd0 || det_cnt !== 3'd0 || test_ip !== 4'd0)
      $display("FAIL restart got busy=%b flt=%0d det=%0d tip=%0d exp 1 0 0 0",
               busy, cur_fault, det_cnt, test_ip);
    else n_pass++;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_next();
    int cnt;
    fill_table(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (inc !== 1'b1 && cnt < BUDGET);
    n_checks++;
    if (inc !== 1'b1) $display("FAIL reset_next_reach got inc=%b exp 1", inc);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({test_ip, inc, busy, done, cur_fault, det_cnt} !== '0)
      $display("FAIL reset_mid_next got tip=%0h inc=%b busy=%b done=%b flt=%0d det=%0d exp 0",
               test_ip, inc, busy, done, cur_fault, det_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    fill_table(2);
    check_run("start_held", 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || test_ip !== 4'd0 || cur_fault !== 2'd0 ||
        det_cnt !== 3'd0)
      $display("FAIL back_to_back got busy=%b done=%b tip=%0d flt=%0d det=%0d exp 1 0 0 0 0",
               busy, done, test_ip, cur_fault, det_cnt);
    else n_pass++;
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_mismatch();
    test_single_mismatch();
    test_all_mismatch();
    test_random();
    test_abort();
    test_reset_mid_next();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
